arm_exec_unit: RTL and testbench

ARM_EXEC_UNIT -- requirements
Module: arm_exec_unit

---
 rtl/arm_exec_pkg.sv | 52 +++++
 rtl/arm_exec_if.sv | 45 ++++
 rtl/arm_alu.sv | 44 ++++
 rtl/arm_exec_unit.sv | 153 +++++++++++++++
 tb/tb_arm_exec_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/arm_exec_pkg.sv
// Shared constants and types for the ARM execute slice.
// Decoder, ALU and flag logic all import this package.
package arm_exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;
    localparam logic [2:0] ALU_SBC = 3'b101;
    localparam logic [2:0] ALU_EOR = 3'b110;
    localparam logic [2:0] ALU_RSB = 3'b111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/arm_exec_if.sv
// arm_alu_if: operand/result bus between decoder and ALU.
// arm_exec_if: instruction/control bundle of the execute unit.
interface arm_alu_if;
    import arm_exec_pkg::*;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        cin;
    logic [31:0] result;
    flags_t      flags;

    modport master (output a, b, ctrl, cin, input result, flags);
    modport slave  (input a, b, ctrl, cin, output result, flags);
endinterface

interface arm_exec_if;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        pc_src;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  imm_src;
    logic [1:0]  reg_src;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;

    modport master (
        output cond, op, funct, rd, src_a, src_b,
        input  pc_src, reg_write, mem_write, mem_to_reg, alu_src,
        input  imm_src, reg_src, alu_control, alu_result, alu_flags, flags
    );
    modport slave (
        input  cond, op, funct, rd, src_a, src_b,
        output pc_src, reg_write, mem_write, mem_to_reg, alu_src,
        output imm_src, reg_src, alu_control, alu_result, alu_flags, flags
    );
endinterface

// File: rtl/arm_alu.sv
// 32-bit ALU; all arithmetic ops share one adder as x + y + cin.
// RSB swaps operands so that V and C come out of the same adder.
module arm_alu
    import arm_exec_pkg::*;
(
    arm_alu_if.slave bus
);

    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        arith;
    logic [31:0] lres;
    logic [32:0] sum;

    always_comb begin
        x     = bus.a;
        y     = bus.b;
        cin   = 1'b0;
        arith = 1'b1;
        lres  = '0;
        case (bus.ctrl)
            ALU_SUB: begin y = ~bus.b; cin = 1'b1; end
            ALU_ADC: cin = bus.cin;
            ALU_SBC: begin y = ~bus.b; cin = bus.cin; end
            ALU_RSB: begin x = bus.b; y = ~bus.a; cin = 1'b1; end
            ALU_AND: begin arith = 1'b0; lres = bus.a & bus.b; end
            ALU_ORR: begin arith = 1'b0; lres = bus.a | bus.b; end
            ALU_EOR: begin arith = 1'b0; lres = bus.a ^ bus.b; end
            default: ;
        endcase
    end

    assign sum        = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    assign bus.result = arith ? sum[31:0] : lres;

    always_comb begin
        bus.flags.n = bus.result[31];
        bus.flags.z = (bus.result == 32'd0);
        bus.flags.c = arith & sum[32];
        bus.flags.v = arith & (x[31] == y[31]) & (sum[31] ^ x[31]);
    end

endmodule

// File: rtl/arm_exec_unit.sv
// ARM single-cycle decode/condition/ALU slice with registered NZCV.
// Define ARM_EXEC_CARRY_OPS_EN to enable ADC, SBC and RSB.
module arm_exec_unit
    import arm_exec_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  Cond,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic [3:0]  ALUFlags,
    output logic [3:0]  Flags
);

    flags_t     flags_q;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       dp_ok;
    logic       arith;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic [3:0] cmd;

    assign cmd = Funct[4:1];

    always_comb begin
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        dp_ok      = 1'b0;
        arith      = 1'b1;
        flag_w     = 2'b00;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        unique case (1'b1)
            (Op == OP_DP): begin
                dp_ok = 1'b1;
                case (cmd)
                    CMD_ADD: begin ALUControl = ALU_ADD; reg_w = 1'b1; end
                    CMD_SUB: begin ALUControl = ALU_SUB; reg_w = 1'b1; end
                    CMD_AND: begin ALUControl = ALU_AND; reg_w = 1'b1; arith = 1'b0; end
                    CMD_ORR: begin ALUControl = ALU_ORR; reg_w = 1'b1; arith = 1'b0; end
                    CMD_EOR: begin ALUControl = ALU_EOR; reg_w = 1'b1; arith = 1'b0; end
                    CMD_CMP: ALUControl = ALU_SUB;
                    CMD_CMN: ALUControl = ALU_ADD;
`ifdef ARM_EXEC_CARRY_OPS_EN
                    CMD_ADC: begin ALUControl = ALU_ADC; reg_w = 1'b1; end
                    CMD_SBC: begin ALUControl = ALU_SBC; reg_w = 1'b1; end
                    CMD_RSB: begin ALUControl = ALU_RSB; reg_w = 1'b1; end
`endif
                    default: dp_ok = 1'b0;
                endcase
                // Undefined cmd codes leave every output at its idle value
                if (dp_ok) begin
                    ALUSrc    = Funct[5];
                    flag_w[1] = Funct[0];
                    flag_w[0] = Funct[0] & arith;
                end else begin
                    ALUControl = ALU_ADD;
                end
            end
            (Op == OP_MEM): begin
                ALUSrc     = 1'b1;
                ImmSrc     = 2'b01;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                if (Funct[0]) begin
                    reg_w    = 1'b1;
                    MemtoReg = 1'b1;
                end else begin
                    mem_w  = 1'b1;
                    RegSrc = 2'b10;
                end
            end
            (Op == OP_BR): begin
                ALUSrc = 1'b1;
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (Cond)
            COND_EQ: cond_ex = flags_q.z;
            COND_NE: cond_ex = ~flags_q.z;
            COND_CS: cond_ex = flags_q.c;
            COND_CC: cond_ex = ~flags_q.c;
            COND_MI: cond_ex = flags_q.n;
            COND_PL: cond_ex = ~flags_q.n;
            COND_VS: cond_ex = flags_q.v;
            COND_VC: cond_ex = ~flags_q.v;
            COND_HI: cond_ex = flags_q.c & ~flags_q.z;
            COND_LS: cond_ex = ~flags_q.c | flags_q.z;
            COND_GE: cond_ex = (flags_q.n == flags_q.v);
            COND_LT: cond_ex = (flags_q.n != flags_q.v);
            COND_GT: cond_ex = ~flags_q.z & (flags_q.n == flags_q.v);
            COND_LE: cond_ex = flags_q.z | (flags_q.n != flags_q.v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign PCSrc    = (branch | (reg_w & (Rd == 4'd15))) & cond_ex;
    assign RegWrite = reg_w & cond_ex;
    assign MemWrite = mem_w & cond_ex;

    arm_alu_if alu_bus ();

    assign alu_bus.a    = SrcA;
    assign alu_bus.b    = SrcB;
    assign alu_bus.ctrl = ALUControl;
    assign alu_bus.cin  = flags_q.c;

    arm_alu u_alu (.bus(alu_bus.slave));

    assign ALUResult = alu_bus.result;
    assign ALUFlags  = alu_bus.flags;
    assign Flags     = flags_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= '0;
        end else if (cond_ex) begin
            if (flag_w[1]) begin
                flags_q.n <= alu_bus.flags.n;
                flags_q.z <= alu_bus.flags.z;
            end
            if (flag_w[0]) begin
                flags_q.c <= alu_bus.flags.c;
                flags_q.v <= alu_bus.flags.v;
            end
        end
    end

endmodule

// File: tb/tb_arm_exec_unit.sv
// Vector table for arm_exec_unit; registered flags go through a queue.
// Expectations for ADC follow ARM_EXEC_CARRY_OPS_EN.
module tb_arm_exec_unit;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    arm_exec_if bus ();

    arm_exec_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Cond       (bus.cond),
        .Op         (bus.op),
        .Funct      (bus.funct),
        .Rd         (bus.rd),
        .SrcA       (bus.src_a),
        .SrcB       (bus.src_b),
        .PCSrc      (bus.pc_src),
        .RegWrite   (bus.reg_write),
        .MemWrite   (bus.mem_write),
        .MemtoReg   (bus.mem_to_reg),
        .ALUSrc     (bus.alu_src),
        .ImmSrc     (bus.imm_src),
        .RegSrc     (bus.reg_src),
        .ALUControl (bus.alu_control),
        .ALUResult  (bus.alu_result),
        .ALUFlags   (bus.alu_flags),
        .Flags      (bus.flags)
    );

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        regw;
        logic        memw;
        logic        pcs;
        logic        m2r;
        logic [1:0]  imm;
        logic [1:0]  rsrc;
        logic [2:0]  ctrl;
        logic        chk;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t       tv[$];
    logic [3:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t mk(
        input logic [3:0] cond, input logic [1:0] op,
        input logic [5:0] funct, input logic [3:0] rd,
        input logic [31:0] a, input logic [31:0] b,
        input logic regw, input logic memw, input logic pcs,
        input logic m2r, input logic [1:0] imm, input logic [1:0] rsrc,
        input logic [2:0] ctrl, input logic chk,
        input logic [31:0] res, input logic [3:0] flg);
        vec_t v;
        v.cond = cond; v.op = op; v.funct = funct; v.rd = rd;
        v.a = a; v.b = b; v.regw = regw; v.memw = memw;
        v.pcs = pcs; v.m2r = m2r; v.imm = imm; v.rsrc = rsrc;
        v.ctrl = ctrl; v.chk = chk; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.cond  = v.cond;
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.rd    = v.rd;
        bus.src_a = v.a;
        bus.src_b = v.b;
    endtask

    task automatic check_flags(input string nm);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            chk(nm, {28'd0, bus.flags}, {28'd0, e});
        end
    endtask

    initial begin
        tv.push_back(mk(4'hE, 2'b00, 6'b001001, 4'd1, 32'h7FFFFFFF, 32'h1,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'h80000000, 4'b1001));
        tv.push_back(mk(4'hE, 2'b00, 6'b010101, 4'd0, 32'd5, 32'd5,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 32'd0, 4'b0110));
        tv.push_back(mk(4'h0, 2'b00, 6'b001000, 4'd2, 32'd2, 32'd3,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd5, 4'b0110));
        tv.push_back(mk(4'h1, 2'b00, 6'b001001, 4'd2, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd2, 4'b0110));
        tv.push_back(mk(4'hE, 2'b01, 6'b011000, 4'd3, 32'd100, 32'd4,
                        0, 1, 0, 0, 2'b01, 2'b10, 3'b000, 1, 32'd104, 4'b0110));
        tv.push_back(mk(4'hE, 2'b01, 6'b010000, 4'd3, 32'd100, 32'd4,
                        0, 1, 0, 0, 2'b01, 2'b10, 3'b001, 1, 32'd96, 4'b0110));
        tv.push_back(mk(4'hE, 2'b01, 6'b011001, 4'd3, 32'd100, 32'd4,
                        1, 0, 0, 1, 2'b01, 2'b00, 3'b000, 1, 32'd104, 4'b0110));
        tv.push_back(mk(4'hE, 2'b10, 6'b000000, 4'd0, 32'd8, 32'd16,
                        0, 0, 1, 0, 2'b10, 2'b01, 3'b000, 1, 32'd24, 4'b0110));
        tv.push_back(mk(4'hE, 2'b00, 6'b001000, 4'd15, 32'd4, 32'd4,
                        1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 1, 32'd8, 4'b0110));
`ifdef ARM_EXEC_CARRY_OPS_EN
        tv.push_back(mk(4'hE, 2'b00, 6'b001010, 4'd1, 32'd1, 32'd1,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b100, 1, 32'd3, 4'b0110));
`else
        tv.push_back(mk(4'hE, 2'b00, 6'b001010, 4'd1, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 32'd0, 4'b0110));
`endif
        tv.push_back(mk(4'hE, 2'b00, 6'b000001, 4'd1, 32'hF0F0F0F0, 32'h0FF00FF0,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 32'h00F000F0, 4'b0010));
        tv.push_back(mk(4'hE, 2'b00, 6'b111000, 4'd1, 32'd1, 32'd2,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b011, 1, 32'd3, 4'b0010));
        tv.push_back(mk(4'hE, 2'b00, 6'b000011, 4'd1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b110, 1, 32'h80000000, 4'b1010));
        tv.push_back(mk(4'hE, 2'b11, 6'b000000, 4'd1, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 32'd0, 4'b1010));
        tv.push_back(mk(4'hE, 2'b00, 6'b010111, 4'd0, 32'hFFFFFFFF, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd0, 4'b0110));
        tv.push_back(mk(4'hF, 2'b00, 6'b001000, 4'd1, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd2, 4'b0110));
        tv.push_back(mk(4'hE, 2'b00, 6'b000101, 4'd1, 32'd0, 32'd1,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 32'hFFFFFFFF, 4'b1000));
        tv.push_back(mk(4'hA, 2'b00, 6'b001000, 4'd1, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd2, 4'b1000));
        tv.push_back(mk(4'hB, 2'b00, 6'b001000, 4'd1, 32'd1, 32'd1,
                        1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 32'd2, 4'b1000));
        tv.push_back(mk(4'hE, 2'b00, 6'b001110, 4'd1, 32'd1, 32'd1,
                        0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 32'd0, 4'b1000));

        RESET = 1'b1;
        drive(tv[0]);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_flags", {28'd0, bus.flags}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #1;
            chk($sformatf("r%0d ctrl", i), {29'd0, bus.alu_control}, {29'd0, tv[i].ctrl});
            chk($sformatf("r%0d regw", i), {31'd0, bus.reg_write}, {31'd0, tv[i].regw});
            chk($sformatf("r%0d memw", i), {31'd0, bus.mem_write}, {31'd0, tv[i].memw});
            chk($sformatf("r%0d pcs", i), {31'd0, bus.pc_src}, {31'd0, tv[i].pcs});
            chk($sformatf("r%0d m2r", i), {31'd0, bus.mem_to_reg}, {31'd0, tv[i].m2r});
            chk($sformatf("r%0d imm", i), {30'd0, bus.imm_src}, {30'd0, tv[i].imm});
            chk($sformatf("r%0d rsrc", i), {30'd0, bus.reg_src}, {30'd0, tv[i].rsrc});
            if (tv[i].chk)
                chk($sformatf("r%0d res", i), bus.alu_result, tv[i].res);
            exp_q.push_back(tv[i].flg);
            @(posedge CLK);
            #1;
            check_flags($sformatf("r%0d flags", i));
            @(negedge CLK);
        end

        // Reset wins over a flag-setting ADDS on the same edge
        RESET = 1'b1;
        drive(tv[0]);
        #1;
        chk("rst_res", bus.alu_result, 32'h80000000);
        chk("rst_aluflags", {28'd0, bus.alu_flags}, 32'h9);
        chk("rst_regw", {31'd0, bus.reg_write}, 32'd1);
        exp_q.push_back(4'b0000);
        @(posedge CLK);
        #1;
        check_flags("rst_flags");
        @(negedge CLK);
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
